// File: rtl/fp_conv_pkg.sv
// Shared binary32 constants, rounding-mode encodings and the stage payload
// passed from normalisation to rounding in fixed_to_float_pipe.
package fp_conv_pkg;

    localparam int BIAS   = 127;
    localparam int FRAC_W = 23;
    localparam int EXP_W  = 8;

    localparam logic RND_RNE   = 1'b0;
    localparam logic RND_TRUNC = 1'b1;

    typedef struct packed {
        logic              sign;
        logic              zero;
        logic              mode;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              guard;
        logic              sticky;
    } s2_payload_t;

endpackage

// File: rtl/lzd_norm.sv
// Leading-one detector plus normalising shifter: finds the top set bit of
// mag, moves it to the hidden-bit slot and splits off fraction/guard/sticky.
module lzd_norm
    import fp_conv_pkg::*;
#(
    parameter int W   = 32,
    parameter int M_W = $clog2(W)
) (
    input  logic [W-1:0]      mag,
    output logic [M_W-1:0]    m,
    output logic [FRAC_W:0]   mant,
    output logic              guard,
    output logic              sticky
);

    // Pad below the word so narrow inputs still yield a full fraction and guard bit.
    localparam int EW = W + FRAC_W + 1;

    logic [W-1:0]  norm;
    logic [EW-1:0] ext;

    always_comb begin
        m = '0;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) begin
                m = M_W'(i);
            end
        end
    end

    assign norm   = mag << (M_W'(W - 1) - m);
    assign ext    = {norm, {(FRAC_W + 1){1'b0}}};
    // mant[FRAC_W] is the hidden bit; it is clear only for a zero magnitude.
    assign mant   = ext[EW-1 -: FRAC_W + 1];
    assign guard  = ext[EW-2-FRAC_W];
    assign sticky = |ext[EW-3-FRAC_W:0];

endmodule

// File: rtl/fixed_to_float_pipe.sv
// Three-stage fixed-point to binary32 converter with valid/ready on both
// sides; a single stall signal freezes every stage together.
module fixed_to_float_pipe
    import fp_conv_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int POS_W = $clog2(IN_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   targetnumber,
    input  logic [POS_W-1:0]  fixpointpos,
    input  logic              is_signed,
    input  logic              rnd_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       result,
    output logic              inexact
);

    localparam int M_W = $clog2(IN_W);

    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // ---------------- S1: sign/magnitude, clamped position, mode
    logic              sign_next;
    logic [IN_W-1:0]   mag_next;
    logic [POS_W-1:0]  pos_next;

    logic              s1_valid_reg;
    logic              s1_sign_reg;
    logic              s1_mode_reg;
    logic [IN_W-1:0]   s1_mag_reg;
    logic [POS_W-1:0]  s1_pos_reg;

    assign sign_next = is_signed & targetnumber[IN_W-1];
    // Negation stays within IN_W bits, so the most negative input maps to 2^(IN_W-1).
    assign mag_next  = sign_next ? (~targetnumber + IN_W'(1)) : targetnumber;
    assign pos_next  = (int'(fixpointpos) > IN_W - 1) ? POS_W'(IN_W - 1) : fixpointpos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_mode_reg  <= 1'b0;
            s1_mag_reg   <= '0;
            s1_pos_reg   <= '0;
        end else if (!stall) begin
            s1_valid_reg <= in_valid;
            s1_sign_reg  <= sign_next;
            s1_mode_reg  <= rnd_mode;
            s1_mag_reg   <= mag_next;
            s1_pos_reg   <= pos_next;
        end
    end

    // ---------------- S2: leading-one detect, normalise, unrounded exponent
    logic [M_W-1:0]  lead;
    logic [FRAC_W:0] mant;
    logic            guard;
    logic            sticky;

    lzd_norm #(
        .W   (IN_W),
        .M_W (M_W)
    ) u_lzd_norm (
        .mag    (s1_mag_reg),
        .m      (lead),
        .mant   (mant),
        .guard  (guard),
        .sticky (sticky)
    );

    s2_payload_t s2_next;
    s2_payload_t s2_reg;
    logic        s2_valid_reg;

    always_comb begin
        s2_next        = '0;
        s2_next.sign   = s1_sign_reg;
        s2_next.zero   = !mant[FRAC_W];
        s2_next.mode   = s1_mode_reg;
        s2_next.exp    = EXP_W'(int'(lead) - int'(s1_pos_reg) + BIAS);
        s2_next.frac   = mant[FRAC_W-1:0];
        s2_next.guard  = guard;
        s2_next.sticky = sticky;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_reg       <= '0;
        end else if (!stall) begin
            s2_valid_reg <= s1_valid_reg;
            s2_reg       <= s2_next;
        end
    end

    // ---------------- S3: round, exponent carry, pack
    logic              round_up;
    logic [FRAC_W:0]   frac_sum;
    logic [EXP_W-1:0]  exp_rnd;
    logic [31:0]       result_next;

    assign round_up = (s2_reg.mode != RND_TRUNC) && s2_reg.guard
                      && (s2_reg.sticky || s2_reg.frac[0]);
    assign frac_sum = {1'b0, s2_reg.frac} + (FRAC_W + 1)'(round_up);
    // A carry out of the fraction leaves it all-zero, which is the correct 1.0 mantissa.
    assign exp_rnd  = s2_reg.exp + EXP_W'(frac_sum[FRAC_W]);
    assign result_next = s2_reg.zero ? 32'h0000_0000
                                     : {s2_reg.sign, exp_rnd, frac_sum[FRAC_W-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            inexact   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_valid_reg;
            result    <= result_next;
            inexact   <= s2_reg.guard | s2_reg.sticky;
        end
    end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// Bench for fixed_to_float_pipe: directed vectors, a stalled burst, a reset
// mid-stream and a randomized stream scored against an arithmetic model.
module tb_fixed_to_float_pipe;
    import fp_conv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] targetnumber;
    logic [4:0]  fixpointpos;
    logic        is_signed;
    logic        rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        inexact;

    fixed_to_float_pipe #(.IN_W(32), .POS_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .targetnumber (targetnumber),
        .fixpointpos  (fixpointpos),
        .is_signed    (is_signed),
        .rnd_mode     (rnd_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .inexact      (inexact)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          n_out = 0;
    int          stall_cycles = 0;
    logic [32:0] exp_q[$];
    bit          accepted;
    bit          use_fixed;
    logic [32:0] fixed_exp;
    bit          prev_stalled;
    logic [31:0] prev_result;
    logic        prev_inexact;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Exact value arithmetic: locate the exponent, divide off the excess bits
    // and round on the integer remainder.
    function automatic logic [32:0] model(logic [31:0] tn, int fix, bit sgn, bit trunc);
        longint unsigned mag, mant, rem, half;
        bit s;
        int m, e, sh;
        if (fix > 31) fix = 31;
        s = sgn && tn[31];
        mag = s ? (64'h1_0000_0000 - {32'b0, tn}) : {32'b0, tn};
        if (mag == 0) return 33'h0;
        m = 0;
        for (int i = 0; i < 64; i++) if (mag >= (64'd1 << i)) m = i;
        if (m <= 23) begin
            mant = mag << (23 - m);
            rem  = 0;
            half = 1;
        end else begin
            sh   = m - 23;
            mant = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
        end
        if (!trunc && (rem > half || (rem == half && mant[0]))) mant++;
        e = m - fix + BIAS;
        if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e++;
        end
        return {s, 8'(e), mant[22:0], (rem != 0)};
    endfunction

    // One clock: check outputs at the falling edge, log transfers, then step.
    task automatic cycle();
        logic        stalled;
        logic [32:0] e;
        @(negedge clk);
        stalled = out_valid && !out_ready;
        if (stalled) stall_cycles++;
        chk("in_ready_vs_stall", in_ready, !stalled);
        if (prev_stalled) begin
            chk("hold_result", result, prev_result);
            chk("hold_inexact", inexact, prev_inexact);
            chk("hold_valid", out_valid, 1'b1);
        end
        prev_stalled = stalled;
        prev_result  = result;
        prev_inexact = inexact;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("result", result, e[32:1]);
                chk("inexact", inexact, e[0]);
                n_out++;
                $display("out %0d: result=%h inexact=%0d (want %h/%0d)", n_out, result, inexact, e[32:1], e[0]);
            end
        end
        accepted = in_valid && in_ready;
        if (accepted)
            exp_q.push_back(use_fixed ? fixed_exp
                                      : model(targetnumber, int'(fixpointpos), is_signed, rnd_mode));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic directed(logic [31:0] tn, logic [4:0] fix, bit s, bit r, logic [31:0] er, bit ei);
        targetnumber = tn;
        fixpointpos  = fix;
        is_signed    = s;
        rnd_mode     = r;
        in_valid     = 1'b1;
        out_ready    = 1'b1;
        use_fixed    = 1'b1;
        fixed_exp    = {er, ei};
        cycle();
        chk("directed_accept", accepted, 1'b1);
        in_valid  = 1'b0;
        use_fixed = 1'b0;
        drain(20);
    endtask

    task automatic rand_inputs();
        targetnumber = $urandom >> $urandom_range(0, 31);
        fixpointpos  = 5'($urandom_range(0, 31));
        is_signed    = 1'($urandom_range(0, 1));
        rnd_mode     = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int sent, cyc, base, stall_base;
        rst = 1'b1;
        in_valid = 1'b0;
        targetnumber = '0;
        fixpointpos = '0;
        is_signed = 1'b0;
        rnd_mode = RND_RNE;
        out_ready = 1'b1;
        use_fixed = 1'b0;
        prev_stalled = 1'b0;

        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_result", result, 32'h0);
        chk("rst_inexact", inexact, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_in_ready", in_ready, 1'b1);

        directed(32'h0000_0001, 5'd0, 1'b1, RND_RNE,   32'h3F80_0000, 1'b0);
        directed(32'h0000_0000, 5'd0, 1'b1, RND_RNE,   32'h0000_0000, 1'b0);
        directed(32'hFFFF_FFFF, 5'd0, 1'b1, RND_RNE,   32'hBF80_0000, 1'b0);
        directed(32'h8000_0000, 5'd0, 1'b1, RND_RNE,   32'hCF00_0000, 1'b0);
        directed(32'h8000_0000, 5'd0, 1'b0, RND_RNE,   32'h4F00_0000, 1'b0);
        directed(32'h0000_0180, 5'd8, 1'b1, RND_RNE,   32'h3FC0_0000, 1'b0);
        directed(32'h0100_0003, 5'd0, 1'b1, RND_RNE,   32'h4B80_0002, 1'b1);
        directed(32'h0100_0003, 5'd0, 1'b1, RND_TRUNC, 32'h4B80_0001, 1'b1);
        directed(32'h0100_0001, 5'd0, 1'b1, RND_RNE,   32'h4B80_0000, 1'b1);
        directed(32'h0100_0001, 5'd0, 1'b1, RND_TRUNC, 32'h4B80_0000, 1'b1);

        // Eight back-to-back samples with a five-cycle downstream stall.
        base = n_out;
        stall_base = stall_cycles;
        sent = 0;
        cyc = 0;
        rand_inputs();
        in_valid = 1'b1;
        while (sent < 8 && cyc < 100) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            cycle();
            if (accepted) begin
                sent++;
                rand_inputs();
            end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(30);
        chk("burst_count", n_out - base, 8);
        chk("burst_stall_cycles", stall_cycles - stall_base, 5);

        // Reset with two samples in flight.
        rand_inputs();
        in_valid = 1'b1;
        cycle();
        rand_inputs();
        cycle();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_result", result, 32'h0);
        exp_q.delete();
        prev_stalled = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) cycle();
        chk("midrst_no_stale", exp_q.size(), 0);

        // Randomized stream with random valid/ready.
        base = n_out;
        sent = 0;
        cyc = 0;
        rand_inputs();
        while (sent < 300 && cyc < 3000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
            if (accepted) begin
                sent++;
                rand_inputs();
            end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(40);
        chk("random_count", n_out - base, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
